cpu_param_core: RTL and testbench

//  Parametrised accumulator CPU core; successor of the fixed 4-bit cpu. Width/depth set by parameters.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/cpu_alu.sv | 58 +++++
 rtl/cpu_param_core.sv | 148 ++++++++++++++
 tb/tb_cpu_param_core.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode, state and instruction helper definitions for cpu_param_core
package cpu_pkg;

   // Instruction word is {opcode[OP_W-1:0], operand[DATA_W-1:0]}
   localparam int OP_W = 4;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_LOAD_A = 4'h1;
   localparam logic [3:0] OP_LOAD_B = 4'h2;
   localparam logic [3:0] OP_ADD    = 4'h3;
   localparam logic [3:0] OP_SUB    = 4'h4;
   localparam logic [3:0] OP_AND    = 4'h5;
   localparam logic [3:0] OP_OR     = 4'h6;
   localparam logic [3:0] OP_XOR    = 4'h7;
   localparam logic [3:0] OP_NOT    = 4'h8;
   localparam logic [3:0] OP_SHL    = 4'h9;
   localparam logic [3:0] OP_SHR    = 4'hA;
   localparam logic [3:0] OP_JUMP   = 4'hB;
   localparam logic [3:0] OP_JUMP_Z = 4'hC;
   localparam logic [3:0] OP_JUMP_C = 4'hD;
   localparam logic [3:0] OP_OUT    = 4'hE;
   localparam logic [3:0] OP_HALT   = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_EXEC     = 3'd2,
      ST_OUT_WAIT = 3'd3,
      ST_HALT     = 3'd4
   } state_t;

   // Opcodes ADD..SHR write the ALU result back to A and update the flags
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_SHR);
   endfunction

   // Caller passes c=0 when the carry flag does not exist, so JUMP_C falls through
   function automatic logic jump_taken(input logic [3:0] op, input logic z, input logic c);
      return (op == OP_JUMP) || ((op == OP_JUMP_Z) && z) || ((op == OP_JUMP_C) && c);
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU for cpu_param_core
// Purpose: computes the A-register result, zero and (with CPU_CARRY_EN) carry for opcodes ADD..SHR.
// Ports:
//   i_a, i_b  operands (DATA_W)
//   i_op      4-bit opcode
//   o_result  result, modulo 2**DATA_W
//   o_zero    result == 0
//   o_carry   carry/borrow/shifted-out bit (present only when CPU_CARRY_EN is defined)
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [3:0]        i_op,
   output logic [DATA_W-1:0] o_result,
`ifdef CPU_CARRY_EN
   output logic              o_carry,
`endif
   output logic              o_zero
);

   always_comb begin
      o_result = i_a;
      case (i_op)
         OP_ADD:  o_result = i_a + i_b;
         OP_SUB:  o_result = i_a - i_b;
         OP_AND:  o_result = i_a & i_b;
         OP_OR:   o_result = i_a | i_b;
         OP_XOR:  o_result = i_a ^ i_b;
         OP_NOT:  o_result = ~i_a;
         OP_SHL:  o_result = i_a << 1;
         OP_SHR:  o_result = i_a >> 1;
         default: o_result = i_a;
      endcase
   end

   assign o_zero = (o_result == '0);

`ifdef CPU_CARRY_EN
   logic [DATA_W:0] w_sum;
   assign w_sum = {1'b0, i_a} + {1'b0, i_b};

   // Logic ops clear C; SUB reports borrow; shifts report the bit shifted out
   always_comb begin
      o_carry = 1'b0;
      case (i_op)
         OP_ADD:  o_carry = w_sum[DATA_W];
         OP_SUB:  o_carry = (i_a < i_b);
         OP_SHL:  o_carry = i_a[DATA_W-1];
         OP_SHR:  o_carry = i_a[0];
         default: o_carry = 1'b0;
      endcase
   end
`endif

endmodule

// File: rtl/cpu_param_core.sv
// rtl/cpu_param_core.sv - parametrised accumulator CPU with writable program memory and output handshake
// Purpose: fetch/execute FSM running a program from imem; ALU results go to A; OUT presents A on a
//   valid/ready port and waits for the sink. Optional macro CPU_CARRY_EN adds the carry flag and JUMP_C.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start                   run from pc=0 (IDLE/HALT only)
//   imem_we/waddr/wdata     program write port (IDLE/HALT only), word = {opcode, operand}
//   out_data/valid/ready    output handshake, data held while valid
//   busy, halted            FETCH/EXEC/OUT_WAIT, HALT
//   pc_o, zero_flag, carry_flag   architectural state
module cpu_param_core
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  imem_we,
   input  logic [ADDR_W-1:0]     imem_waddr,
   input  logic [4+DATA_W-1:0]   imem_wdata,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  halted,
   output logic [ADDR_W-1:0]     pc_o,
   output logic                  zero_flag,
   output logic                  carry_flag
);

   localparam int IW    = OP_W + DATA_W;
   localparam int DEPTH = 2 ** ADDR_W;

   state_t              r_state, w_state_next;
   logic [IW-1:0]       r_imem [DEPTH];
   logic [IW-1:0]       r_ir;
   logic [ADDR_W-1:0]   r_pc, w_pc_inc;
   logic [DATA_W-1:0]   r_a, r_b, r_out_data;
   logic                r_z, r_out_valid;
   logic [3:0]          w_op;
   logic [DATA_W-1:0]   w_opnd, w_alu_result;
   logic                w_alu_zero, w_carry, w_ctrl_idle;

   assign w_op        = r_ir[DATA_W +: OP_W];
   assign w_opnd      = r_ir[DATA_W-1:0];
   assign w_pc_inc    = r_pc + ADDR_W'(1);
   assign w_ctrl_idle = (r_state == ST_IDLE) || (r_state == ST_HALT);

`ifdef CPU_CARRY_EN
   logic r_c, w_alu_carry;
   assign w_carry = r_c;
`else
   assign w_carry = 1'b0;
`endif

   cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .i_a      (r_a),
      .i_b      (r_b),
      .i_op     (w_op),
      .o_result (w_alu_result),
`ifdef CPU_CARRY_EN
      .o_carry  (w_alu_carry),
`endif
      .o_zero   (w_alu_zero)
   );

   // Program memory has no reset; a write coinciding with start is visible to the first FETCH
   always_ff @(posedge clk) begin
      if (imem_we && w_ctrl_idle)
         r_imem[imem_waddr] <= imem_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE, ST_HALT: if (start) w_state_next = ST_FETCH;
         ST_FETCH:         w_state_next = ST_EXEC;
         ST_EXEC: begin
            if (w_op == OP_OUT)       w_state_next = ST_OUT_WAIT;
            else if (w_op == OP_HALT) w_state_next = ST_HALT;
            else                      w_state_next = ST_FETCH;
         end
         ST_OUT_WAIT:      if (out_ready) w_state_next = ST_FETCH;
         default:          w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc        <= '0;
         r_ir        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_z         <= 1'b0;
`ifdef CPU_CARRY_EN
         r_c         <= 1'b0;
`endif
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_HALT: if (start) r_pc <= '0;
            ST_FETCH:         r_ir <= r_imem[r_pc];
            ST_EXEC: begin
               if (w_op == OP_LOAD_A) r_a <= w_opnd;
               if (w_op == OP_LOAD_B) r_b <= w_opnd;
               if (is_alu_op(w_op)) begin
                  r_a <= w_alu_result;
                  r_z <= w_alu_zero;
`ifdef CPU_CARRY_EN
                  r_c <= w_alu_carry;
`endif
               end
               // OUT advances pc only once the sink takes the data; HALT parks pc on itself
               if (w_op == OP_OUT) begin
                  r_out_data  <= r_a;
                  r_out_valid <= 1'b1;
               end else if (w_op != OP_HALT) begin
                  r_pc <= jump_taken(w_op, r_z, w_carry) ? w_opnd[ADDR_W-1:0] : w_pc_inc;
               end
            end
            ST_OUT_WAIT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_pc        <= w_pc_inc;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign busy       = (r_state == ST_FETCH) || (r_state == ST_EXEC) || (r_state == ST_OUT_WAIT);
   assign halted     = (r_state == ST_HALT);
   assign pc_o       = r_pc;
   assign zero_flag  = r_z;
   assign carry_flag = w_carry;

endmodule

// File: tb/tb_cpu_param_core.sv
// tb/tb_cpu_param_core.sv - self-checking bench for cpu_param_core against an instruction-level model
module tb_cpu_param_core;

   localparam int DW = 8;
   localparam int AW = 4;
`ifdef CPU_CARRY_EN
   localparam bit CARRY_EN = 1'b1;
`else
   localparam bit CARRY_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          imem_we = 1'b0;
   logic [AW-1:0] imem_waddr = '0;
   logic [11:0]   imem_wdata = '0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          busy, halted, zero_flag, carry_flag;
   logic [AW-1:0] pc_o;

   int n_tests = 0;
   int n_fail  = 0;
   int rdy_mode = 0;
   logic [11:0] prog [16];
   int m_a, m_b, m_z, m_c, exp_pc;
   int exp_q[$];
   int got_q[$];
   bit pend = 1'b0;
   logic [DW-1:0] held;

   cpu_param_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .halted     (halted),
      .pc_o       (pc_o),
      .zero_flag  (zero_flag),
      .carry_flag (carry_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sink: choose ready after each falling edge, record what the next rising edge will transfer
   always begin
      @(negedge clk);
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
      #1;
      if (!reset && out_valid) begin
         if (pend) check("hold_data", out_data, held);
         if (out_ready) begin
            got_q.push_back(int'(out_data));
            pend = 1'b0;
         end else begin
            pend = 1'b1;
            held = out_data;
         end
      end else begin
         pend = 1'b0;
      end
   end

   function automatic logic [11:0] ins(input int op, input int opnd);
      return {op[3:0], opnd[7:0]};
   endfunction

   task automatic model_alu(input int res, input int c);
      m_a = res % 256;
      m_z = (m_a == 0) ? 1 : 0;
      if (CARRY_EN) m_c = c;
   endtask

   // Instruction-level reference: runs prog from address 0 until HALT
   task automatic model_run();
      int pc = 0;
      int op, opnd, steps = 0;
      bit done = 1'b0;
      exp_q.delete();
      while (!done && steps < 200) begin
         op   = int'(prog[pc][11:8]);
         opnd = int'(prog[pc][7:0]);
         steps++;
         case (op)
            1:  m_a = opnd;
            2:  m_b = opnd;
            3:  model_alu(m_a + m_b, (m_a + m_b > 255) ? 1 : 0);
            4:  model_alu(m_a - m_b + 256, (m_a < m_b) ? 1 : 0);
            5:  model_alu(m_a & m_b, 0);
            6:  model_alu(m_a | m_b, 0);
            7:  model_alu(m_a ^ m_b, 0);
            8:  model_alu(255 - m_a, 0);
            9:  model_alu(m_a * 2, (m_a >= 128) ? 1 : 0);
            10: model_alu(m_a / 2, m_a % 2);
            14: exp_q.push_back(m_a);
            default: ;
         endcase
         if (op == 15)                          done = 1'b1;
         else if (op == 11)                     pc = opnd % 16;
         else if (op == 12 && m_z != 0)         pc = opnd % 16;
         else if (op == 13 && CARRY_EN && m_c != 0) pc = opnd % 16;
         else                                   pc = (pc + 1) % 16;
      end
      exp_pc = pc;
   endtask

   task automatic model_reset();
      m_a = 0; m_b = 0; m_z = 0; m_c = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = ins(15, 0);
   endtask

   task automatic load_prog();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         imem_we    = 1'b1;
         imem_waddr = AW'(i);
         imem_wdata = prog[i];
      end
      @(negedge clk);
      imem_we = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halt(input string tag, input int budget);
      int cyc = 0;
      while (!halted && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_halt_wait"}, halted, 1);
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int cyc = 0;
      while (!out_valid && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_valid_wait"}, out_valid, 1);
   endtask

   task automatic run_and_check(input string tag, input int budget);
      got_q.delete();
      model_run();
      pulse_start();
      wait_halt(tag, budget);
      check({tag, "_nout"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_q.size()) check({tag, "_out"}, got_q[i], exp_q[i]);
      check({tag, "_pc"}, pc_o, exp_pc);
      check({tag, "_z"}, zero_flag, m_z);
      check({tag, "_c"}, carry_flag, CARRY_EN ? m_c : 0);
   endtask

   task automatic prog_p1();
      clear_prog();
      prog[0] = ins(1, 10);
      prog[1] = ins(2, 3);
      prog[2] = ins(3, 0);
      prog[3] = ins(14, 0);
      prog[4] = ins(15, 0);
   endtask

   initial begin
      int op, opnd;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_pc", pc_o, 0);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_z", zero_flag, 0);
      check("rst_c", carry_flag, 0);
      reset = 1'b0;

      // basic program, sink always ready
      rdy_mode = 0;
      prog_p1();
      load_prog();
      run_and_check("p1", 100);
      if (got_q.size() > 0) check("p1_val13", got_q[0], 13);
      check("p1_pc4", pc_o, 4);

      // sink stalls for 5 cycles
      do_reset();
      rdy_mode = 2;
      got_q.delete();
      pulse_start();
      wait_valid("stall", 40);
      for (int k = 0; k < 5; k++) begin
         check("stall_valid", out_valid, 1);
         check("stall_data", out_data, 13);
         check("stall_pc", pc_o, 3);
         @(negedge clk);
      end
      rdy_mode = 0;
      wait_halt("stall", 40);
      check("stall_nout", got_q.size(), 1);
      if (got_q.size() > 0) check("stall_val", got_q[0], 13);

      // JUMP_Z taken / not taken
      do_reset();
      clear_prog();
      prog[0] = ins(1, 3); prog[1] = ins(2, 3); prog[2] = ins(4, 0); prog[3] = ins(12, 8'hA7);
      load_prog();
      run_and_check("jz_t", 100);
      check("jz_t_pc7", pc_o, 7);
      check("jz_t_z", zero_flag, 1);
      prog[0] = ins(1, 4);
      load_prog();
      run_and_check("jz_n", 100);
      check("jz_n_pc4", pc_o, 4);

      // carry from ADD and JUMP_C
      do_reset();
      clear_prog();
      prog[0] = ins(1, 8'hF0); prog[1] = ins(2, 8'h20); prog[2] = ins(3, 0); prog[3] = ins(13, 9);
      prog[4] = ins(14, 0); prog[9] = ins(14, 0);
      load_prog();
      run_and_check("jc", 100);
      if (got_q.size() > 0) check("jc_a10", got_q[0], 8'h10);
      check("jc_pc", pc_o, CARRY_EN ? 10 : 5);
      check("jc_flag", carry_flag, CARRY_EN ? 1 : 0);

      // pc wraps from 15 to 0 (second pass sees Z=1)
      do_reset();
      clear_prog();
      prog[0] = ins(12, 5); prog[1] = ins(1, 0); prog[2] = ins(2, 0); prog[3] = ins(6, 0);
      prog[4] = ins(11, 15); prog[15] = ins(0, 0);
      load_prog();
      run_and_check("wrap", 100);
      check("wrap_pc5", pc_o, 5);

      // program writes while running are ignored
      prog_p1();
      load_prog();
      got_q.delete();
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         imem_we    = 1'b1;
         imem_waddr = '0;
         imem_wdata = ins(15, 0);
         check("we_busy", busy, 1);
      end
      @(negedge clk);
      imem_we = 1'b0;
      wait_halt("we_run", 100);
      run_and_check("we_rerun", 100);

      // reset while waiting for the sink
      rdy_mode = 2;
      pulse_start();
      wait_valid("rst_ow", 40);
      @(negedge clk);
      reset = 1'b1;
      #2;
      check("rst_ow_valid", out_valid, 0);
      check("rst_ow_pc", pc_o, 0);
      check("rst_ow_busy", busy, 0);
      check("rst_ow_halted", halted, 0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      rdy_mode = 0;
      run_and_check("rst_rerun", 100);

      // randomized programs with forward-only jumps so each run terminates
      for (int r = 0; r < 24; r++) begin
         rdy_mode = int'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) do_reset();
         for (int i = 0; i < 16; i++) begin
            op = int'($urandom_range(0, 15));
            if (op == 15 && $urandom_range(0, 3) != 0) op = int'($urandom_range(1, 14));
            if (i == 15) op = 15;
            if (op >= 11 && op <= 13)
               opnd = int'($urandom_range(0, 15)) * 16 + int'($urandom_range(i + 1, 15));
            else
               opnd = int'($urandom_range(0, 255));
            prog[i] = ins(op, opnd);
         end
         load_prog();
         run_and_check("rand", 800);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
